// File: rtl/sync_sequencer.sv
// Sequencer for a capture register feeding two slow stages.
// A divided tick paces input acceptance and stage loads.
module sync_sequencer #(
    parameter int DATA_W = 4,
    parameter int DIV_W  = 4
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cap_en,
    output logic             stg1_en,
    output logic             stg2_en,
    output logic             out_valid,
    output logic [1:0]       state,
    output logic [7:0]       done_cnt
);

    if (DATA_W < 1) begin : g_bad_width
        $error("DATA_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_init;
    logic             v0_q;
    logic             v1_q;
    logic             ov_q;
    logic [7:0]       done_q;
    logic             active;
    logic             tick;
    logic             xfer;

    // State register
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, divider tick and the load enables
    always_comb begin
        state_d    = state_q;
        active     = (state_q == S_RUN) || (state_q == S_DRAIN);
        tick       = active && (cnt_q == ratio_q);
        in_ready   = tick && (state_q == S_RUN) && !reset;
        xfer       = in_ready && in_valid;
        cap_en     = xfer;
        stg1_en    = tick && v0_q && !reset;
        stg2_en    = tick && v1_q && !reset;
        ratio_init = (div_ratio == '0) ? ONE : div_ratio;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!v0_q && !v1_q) state_d = S_IDLE;
            end
            S_BAD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider, ratio latch, valid pipe and completion counter
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            cnt_q   <= '0;
            ratio_q <= ONE;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 8'd0;
        end else begin
            ov_q <= stg2_en;
            if (ov_q) done_q <= done_q + 8'd1;
            if (state_q == S_IDLE && start) ratio_q <= ratio_init;
            if (!active || state_d == S_IDLE || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
            if (tick) begin
                v0_q <= xfer;
                v1_q <= v0_q;
            end
        end
    end

    assign out_valid = ov_q;
    assign state     = state_q;
    assign done_cnt  = done_q;

endmodule
